// File: rtl/fft_peak_detector_if.sv
// Stream bundle between the FFT source, the peak detector and the result consumer.
// Handshake: a beat or result moves on a rising clk edge where valid && ready are both high;
// the sender holds data stable while valid=1 and ready=0, and ready never depends on valid.
interface fft_peak_detector_if #(
  parameter int DATA_W = 12,
  parameter int IDX_W  = 10
);
  logic                     source_valid;
  logic                     source_ready;
  logic                     source_sop;
  logic                     source_eop;
  logic [1:0]               source_error;
  logic signed [DATA_W-1:0] source_real;
  logic signed [DATA_W-1:0] source_imag;
  logic                     peak_valid;
  logic                     peak_ready;
  logic [IDX_W-1:0]         peak_bin;
  logic [2*DATA_W-1:0]      peak_power;
  logic                     frame_err;

  modport master (
    output source_valid, source_sop, source_eop, source_error, source_real, source_imag,
    output peak_ready,
    input  source_ready, peak_valid, peak_bin, peak_power, frame_err
  );

  modport slave (
    input  source_valid, source_sop, source_eop, source_error, source_real, source_imag,
    input  peak_ready,
    output source_ready, peak_valid, peak_bin, peak_power, frame_err
  );
endinterface

// File: rtl/fft_peak_detector.sv
// Per-frame peak finder on an FFT output stream: power = re^2+im^2 through a 2-stage
// pipeline, strict-greater running max over in-range bins, one result per good frame.
module fft_peak_detector #(
  parameter int DATA_W        = 12,
  parameter int FFT_PTS       = 1024,
  parameter int IDX_W         = 10,
  parameter int HALF_SPECTRUM = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fft_peak_detector_if.slave   bus,
  output logic [1:0]           o_dbg_state
);
  localparam int PW = 2 * DATA_W;
  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(FFT_PTS - 1);
  localparam logic [IDX_W-1:0] HALF_TOP = IDX_W'(FFT_PTS / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_HOLD} state_t;

  state_t           r_state, w_state_nx;
  logic [IDX_W-1:0] r_bin, w_bin_nx, w_cur_bin;
  logic             r_bad, w_bad_nx;
  logic             r_frame_err, w_err_nx;
  logic             r_drain, w_drain_nx;
  logic             w_ready, w_acc, w_beat_err, w_proc, w_last, w_in_range;

  logic [PW-1:0]    w_re_x, w_im_x, w_re2, w_im2;

  logic             r_s1_valid, r_s1_sop, r_s1_last, r_s1_inr;
  logic [IDX_W-1:0] r_s1_bin;
  logic [PW-1:0]    r_s1_re2, r_s1_im2;
  logic             r_s2_valid, r_s2_sop, r_s2_last, r_s2_inr;
  logic [IDX_W-1:0] r_s2_bin;
  logic [PW-1:0]    r_s2_pow;
  logic [PW-1:0]    r_max_pow, w_floor;
  logic [IDX_W-1:0] r_max_bin;
  logic             r_c_last, w_take;
  logic             r_peak_valid;
  logic [IDX_W-1:0] r_peak_bin;
  logic [PW-1:0]    r_peak_pow;

  assign w_ready    = (r_state == S_IDLE) || (r_state == S_ACC);
  assign w_acc      = bus.source_valid && w_ready;
  assign w_cur_bin  = bus.source_sop ? '0 : r_bin;
  assign w_beat_err = |bus.source_error;
  assign w_in_range = (HALF_SPECTRUM != 0) ? ((w_cur_bin != '0) && (w_cur_bin <= HALF_TOP)) : 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_bin       <= '0;
      r_bad       <= 1'b0;
      r_frame_err <= 1'b0;
      r_drain     <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_bin       <= w_bin_nx;
      r_bad       <= w_bad_nx;
      r_frame_err <= w_err_nx;
      r_drain     <= w_drain_nx;
    end
  end

  // A sop always restarts the frame at bin 0; only a clean eop on the last bin reaches DRAIN.
  always_comb begin
    w_state_nx = r_state;
    w_bin_nx   = r_bin;
    w_bad_nx   = r_bad;
    w_err_nx   = 1'b0;
    w_drain_nx = r_drain;
    w_proc     = 1'b0;
    w_last     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc && bus.source_sop) begin
          w_proc   = 1'b1;
          w_bin_nx = w_cur_bin + 1'b1;
          w_bad_nx = w_beat_err;
          if (bus.source_eop) begin
            w_err_nx   = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (w_acc) begin
          w_proc   = 1'b1;
          w_bin_nx = w_cur_bin + 1'b1;
          if (bus.source_sop) begin
            w_err_nx = 1'b1;
            w_bad_nx = w_beat_err;
            if (bus.source_eop) w_state_nx = S_IDLE;
          end else if (bus.source_eop) begin
            if ((w_cur_bin == LAST_BIN) && !r_bad && !w_beat_err) begin
              w_last     = 1'b1;
              w_drain_nx = 1'b0;
              w_state_nx = S_DRAIN;
            end else begin
              w_err_nx   = 1'b1;
              w_state_nx = S_IDLE;
            end
          end else if (w_cur_bin == LAST_BIN) begin
            w_err_nx   = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_bad_nx = r_bad || w_beat_err;
          end
        end
      end
      S_DRAIN: begin
        if (r_drain) w_state_nx = S_HOLD;
        else         w_drain_nx = 1'b1;
      end
      S_HOLD: begin
        if (r_peak_valid && bus.peak_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Sign-extend before multiplying so the square is formed at full 2*DATA_W width.
  assign w_re_x = {{DATA_W{bus.source_real[DATA_W-1]}}, bus.source_real};
  assign w_im_x = {{DATA_W{bus.source_imag[DATA_W-1]}}, bus.source_imag};
  assign w_re2  = w_re_x * w_re_x;
  assign w_im2  = w_im_x * w_im_x;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0; r_s1_sop <= 1'b0; r_s1_last <= 1'b0; r_s1_inr <= 1'b0;
      r_s1_bin   <= '0;   r_s1_re2 <= '0;   r_s1_im2  <= '0;
      r_s2_valid <= 1'b0; r_s2_sop <= 1'b0; r_s2_last <= 1'b0; r_s2_inr <= 1'b0;
      r_s2_bin   <= '0;   r_s2_pow <= '0;
    end else begin
      r_s1_valid <= w_proc;
      r_s1_sop   <= bus.source_sop;
      r_s1_last  <= w_last;
      r_s1_inr   <= w_in_range;
      r_s1_bin   <= w_cur_bin;
      r_s1_re2   <= w_re2;
      r_s1_im2   <= w_im2;
      r_s2_valid <= r_s1_valid;
      r_s2_sop   <= r_s1_sop;
      r_s2_last  <= r_s1_last;
      r_s2_inr   <= r_s1_inr;
      r_s2_bin   <= r_s1_bin;
      r_s2_pow   <= r_s1_re2 + r_s1_im2;
    end
  end

  // The sop beat compares against zero, so stale beats of a discarded frame never leak in.
  assign w_floor = r_s2_sop ? '0 : r_max_pow;
  assign w_take  = r_s2_valid && r_s2_inr && (r_s2_pow > w_floor);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_max_pow    <= '0;
      r_max_bin    <= '0;
      r_c_last     <= 1'b0;
      r_peak_valid <= 1'b0;
      r_peak_bin   <= '0;
      r_peak_pow   <= '0;
    end else begin
      r_c_last <= r_s2_valid && r_s2_last;
      if (w_take) begin
        r_max_pow <= r_s2_pow;
        r_max_bin <= r_s2_bin;
      end else if (r_s2_valid && r_s2_sop) begin
        r_max_pow <= '0;
        r_max_bin <= '0;
      end
      if (r_c_last) begin
        r_peak_valid <= 1'b1;
        r_peak_bin   <= r_max_bin;
        r_peak_pow   <= r_max_pow;
      end else if (r_peak_valid && bus.peak_ready) begin
        r_peak_valid <= 1'b0;
      end
    end
  end

  assign bus.source_ready = w_ready;
  assign bus.peak_valid   = r_peak_valid;
  assign bus.peak_bin     = r_peak_bin;
  assign bus.peak_power   = r_peak_pow;
  assign bus.frame_err    = r_frame_err;
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_fft_peak_detector.sv
// Bench for fft_peak_detector: frame driver tasks, a per-frame peak model over plain
// arrays, an expected-result queue and one task per scenario.
module tb_fft_peak_detector;
  localparam int DW  = 12;
  localparam int PTS = 1024;
  localparam int IW  = 10;
  localparam int RW  = IW + 2 * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fft_peak_detector_if #(.DATA_W(DW), .IDX_W(IW)) bus ();
  logic [1:0] dbg_state;

  fft_peak_detector #(.DATA_W(DW), .FFT_PTS(PTS), .IDX_W(IW), .HALF_SPECTRUM(1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int err_pulses = 0;
  int valid_rises = 0;
  int rise_edge = -1;
  logic prev_valid = 1'b0;

  int fr_re [PTS];
  int fr_im [PTS];
  bit fr_err [PTS];
  logic [RW-1:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Edge numbers: an edge is numbered by the value cyc held just before it.
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) err_pulses <= err_pulses + 1;
    if (bus.peak_valid === 1'b1 && prev_valid !== 1'b1) begin
      valid_rises <= valid_rises + 1;
      rise_edge   <= cyc - 1;
    end
    prev_valid <= bus.peak_valid;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] model_peak();
    int best_p = 0;
    int best_b = 0;
    for (int b = 1; b <= PTS / 2 - 1; b++) begin
      int p = fr_re[b] * fr_re[b] + fr_im[b] * fr_im[b];
      if (p > best_p) begin
        best_p = p;
        best_b = b;
      end
    end
    return {IW'(best_b), (2 * DW)'(best_p)};
  endfunction

  function automatic void clear_frame();
    for (int i = 0; i < PTS; i++) begin
      fr_re[i] = 0; fr_im[i] = 0; fr_err[i] = 1'b0;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_beat(input int re, input int im, input bit sop, input bit eop, input bit err);
    int guard = 0;
    @(negedge clk);
    bus.source_valid = 1'b1;
    bus.source_sop   = sop;
    bus.source_eop   = eop;
    bus.source_error = err ? 2'($urandom_range(1, 3)) : 2'b00;
    bus.source_real  = re[DW-1:0];
    bus.source_imag  = im[DW-1:0];
    while (bus.source_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++; failures++;
      $display("FAIL beat_accept_timeout: source_ready=%b required 1", bus.source_ready);
    end
    @(posedge clk);
  endtask

  task automatic send_frame(input int n, input bit mark_eop, output int k_eop);
    k_eop = -1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        @(negedge clk);
        bus.source_valid = 1'b0;
      end
      send_beat(fr_re[i], fr_im[i], i == 0, mark_eop && (i == n - 1), fr_err[i]);
      k_eop = cyc;
    end
    @(negedge clk);
    bus.source_valid = 1'b0;
    bus.source_sop   = 1'b0;
    bus.source_eop   = 1'b0;
    bus.source_error = 2'b00;
  endtask

  task automatic wait_result(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.peak_valid === 1'b1) got = 1'b1;
    end
    #1;
  endtask

  task automatic take_result();
    @(negedge clk);
    bus.peak_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.peak_ready = 1'b0;
  endtask

  task automatic run_good_frame(output bit got, output logic [RW-1:0] obs, output int lat);
    int k;
    send_frame(PTS, 1'b1, k);
    wait_result(got);
    obs = {bus.peak_bin, bus.peak_power};
    lat = rise_edge - k;
    if (got) take_result();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    bus.source_valid = 1'b0; bus.source_sop = 1'b0; bus.source_eop = 1'b0;
    bus.source_error = 2'b00; bus.source_real = '0; bus.source_imag = '0;
    bus.peak_ready = 1'b0;
    idle(3);
    checks++; if (bus.source_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", bus.source_ready); end
    checks++; if (bus.peak_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.peak_valid); end
    checks++; if (bus.peak_bin !== '0) begin failures++; $display("FAIL reset_bin: got %0d expected 0", bus.peak_bin); end
    checks++; if (bus.peak_power !== '0) begin failures++; $display("FAIL reset_power: got %0d expected 0", bus.peak_power); end
    checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_clean();
    int k, e0;
    bit got;
    logic [RW-1:0] exp;
    clear_frame();
    fr_re[37] = 100; fr_im[37] = -50;
    exp_q.push_back(model_peak());
    e0 = err_pulses;
    send_frame(PTS, 1'b1, k);
    checks++; if (bus.source_ready !== 1'b0) begin failures++; $display("FAIL drain_ready: got %b expected 0", bus.source_ready); end
    wait_result(got);
    exp = exp_q.pop_front();
    checks++; if (!got) begin failures++; $display("FAIL clean_result_timeout: peak_valid=%b expected 1", bus.peak_valid); end
    checks++; if (rise_edge !== k + 3) begin failures++; $display("FAIL clean_latency: got edge %0d expected %0d", rise_edge, k + 3); end
    checks++; if ({bus.peak_bin, bus.peak_power} !== exp) begin failures++; $display("FAIL clean_peak: got bin %0d power %0d expected bin %0d power %0d", bus.peak_bin, bus.peak_power, exp[RW-1 -: IW], exp[2*DW-1:0]); end
    take_result();
    checks++; if (bus.peak_valid !== 1'b0) begin failures++; $display("FAIL clean_valid_drop: got %b expected 0", bus.peak_valid); end
    checks++; if (bus.source_ready !== 1'b1) begin failures++; $display("FAIL clean_ready_back: got %b expected 1", bus.source_ready); end
    checks++; if (err_pulses !== e0) begin failures++; $display("FAIL clean_no_err: got %0d pulses expected %0d", err_pulses, e0); end
  endtask

  task automatic test_ties();
    bit got; int lat;
    logic [RW-1:0] obs, exp;
    clear_frame();
    fr_re[5] = 300; fr_im[5] = 400;
    fr_re[9] = 300; fr_im[9] = 400;
    exp_q.push_back(model_peak());
    run_good_frame(got, obs, lat);
    exp = exp_q.pop_front();
    checks++; if (!got || obs !== exp) begin failures++; $display("FAIL ties_peak: got valid %b bin %0d power %0d expected bin %0d power %0d", got, obs[RW-1 -: IW], obs[2*DW-1:0], exp[RW-1 -: IW], exp[2*DW-1:0]); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL ties_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_full_scale();
    bit got; int lat;
    logic [RW-1:0] obs, exp;
    clear_frame();
    fr_re[511] = -2048; fr_im[511] = -2048;
    exp_q.push_back(model_peak());
    run_good_frame(got, obs, lat);
    exp = exp_q.pop_front();
    checks++; if (!got || obs !== exp) begin failures++; $display("FAIL full_scale_peak: got valid %b bin %0d power %0d expected bin %0d power %0d", got, obs[RW-1 -: IW], obs[2*DW-1:0], exp[RW-1 -: IW], exp[2*DW-1:0]); end
    clear_frame();
    fr_re[0] = -2048;   fr_im[0] = -2048;
    fr_re[600] = -2048; fr_im[600] = -2048;
    exp_q.push_back(model_peak());
    run_good_frame(got, obs, lat);
    exp = exp_q.pop_front();
    checks++; if (!got || obs !== exp) begin failures++; $display("FAIL out_of_range_ignored: got valid %b bin %0d power %0d expected bin %0d power %0d", got, obs[RW-1 -: IW], obs[2*DW-1:0], exp[RW-1 -: IW], exp[2*DW-1:0]); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL out_of_range_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_random();
    bit got; int lat;
    logic [RW-1:0] obs, exp;
    for (int f = 0; f < 3; f++) begin
      clear_frame();
      for (int i = 0; i < PTS; i++) begin
        // Frame 2 is sparse so the winner is a single outlier among mostly-zero bins.
        if (f != 2 || $urandom_range(0, 63) == 0) begin
          fr_re[i] = int'($urandom_range(0, 4095)) - 2048;
          fr_im[i] = int'($urandom_range(0, 4095)) - 2048;
        end
      end
      exp_q.push_back(model_peak());
      run_good_frame(got, obs, lat);
      exp = exp_q.pop_front();
      checks++; if (!got || obs !== exp) begin failures++; $display("FAIL random_peak[%0d]: got valid %b bin %0d power %0d expected bin %0d power %0d", f, got, obs[RW-1 -: IW], obs[2*DW-1:0], exp[RW-1 -: IW], exp[2*DW-1:0]); end
      checks++; if (lat !== 3) begin failures++; $display("FAIL random_latency[%0d]: got %0d expected 3", f, lat); end
    end
  endtask

  task automatic test_malformed();
    int k, e0, v0, lat;
    bit got;
    logic [RW-1:0] obs, exp;
    // Early eop at bin 500.
    clear_frame();
    fr_re[40] = 900; fr_im[40] = 900;
    e0 = err_pulses; v0 = valid_rises;
    send_frame(501, 1'b1, k);
    idle(10);
    checks++; if (err_pulses !== e0 + 1) begin failures++; $display("FAIL short_frame_err: got %0d pulses expected %0d", err_pulses - e0, 1); end
    checks++; if (valid_rises !== v0) begin failures++; $display("FAIL short_frame_no_result: got %0d results expected 0", valid_rises - v0); end
    // Beats without sop while idle are ignored.
    e0 = err_pulses;
    for (int i = 0; i < 3; i++) send_beat(1000, 1000, 1'b0, 1'b1, 1'b0);
    @(negedge clk); bus.source_valid = 1'b0; bus.source_eop = 1'b0;
    idle(8);
    checks++; if (err_pulses !== e0 || valid_rises !== v0) begin failures++; $display("FAIL idle_ignore: got err %0d results %0d expected 0 and 0", err_pulses - e0, valid_rises - v0); end
    clear_frame();
    fr_re[123] = 7; fr_im[123] = -9;
    exp_q.push_back(model_peak());
    run_good_frame(got, obs, lat);
    exp = exp_q.pop_front();
    checks++; if (!got || obs !== exp) begin failures++; $display("FAIL after_short_peak: got valid %b bin %0d power %0d expected bin %0d power %0d", got, obs[RW-1 -: IW], obs[2*DW-1:0], exp[RW-1 -: IW], exp[2*DW-1:0]); end
    // sop arriving at bin 200 restarts the frame.
    clear_frame();
    fr_re[150] = 2000; fr_im[150] = 2000;
    e0 = err_pulses;
    send_frame(200, 1'b0, k);
    clear_frame();
    fr_re[250] = -321; fr_im[250] = 77;
    exp_q.push_back(model_peak());
    run_good_frame(got, obs, lat);
    exp = exp_q.pop_front();
    checks++; if (err_pulses !== e0 + 1) begin failures++; $display("FAIL restart_err: got %0d pulses expected 1", err_pulses - e0); end
    checks++; if (!got || obs !== exp || lat !== 3) begin failures++; $display("FAIL restart_peak: got valid %b bin %0d power %0d lat %0d expected bin %0d power %0d lat 3", got, obs[RW-1 -: IW], obs[2*DW-1:0], lat, exp[RW-1 -: IW], exp[2*DW-1:0]); end
    // Bin 1023 without eop wraps.
    clear_frame();
    fr_re[30] = 500; fr_im[30] = 1;
    e0 = err_pulses; v0 = valid_rises;
    send_frame(PTS, 1'b0, k);
    idle(10);
    checks++; if (err_pulses !== e0 + 1 || valid_rises !== v0) begin failures++; $display("FAIL wrap_err: got err %0d results %0d expected 1 and 0", err_pulses - e0, valid_rises - v0); end
  endtask

  task automatic test_error_beat();
    int k, e0, v0;
    clear_frame();
    fr_re[37] = 100; fr_im[37] = -50;
    fr_err[10] = 1'b1;
    e0 = err_pulses; v0 = valid_rises;
    send_frame(PTS, 1'b1, k);
    idle(10);
    checks++; if (err_pulses !== e0 + 1) begin failures++; $display("FAIL error_beat_err: got %0d pulses expected 1", err_pulses - e0); end
    checks++; if (valid_rises !== v0) begin failures++; $display("FAIL error_beat_no_result: got %0d results expected 0", valid_rises - v0); end
  endtask

  task automatic test_backpressure();
    int k;
    bit got;
    logic [RW-1:0] exp;
    clear_frame();
    fr_re[$urandom_range(1, 511)] = int'($urandom_range(1, 2047));
    fr_im[$urandom_range(1, 511)] = -int'($urandom_range(1, 2047));
    exp_q.push_back(model_peak());
    send_frame(PTS, 1'b1, k);
    wait_result(got);
    exp = exp_q.pop_front();
    checks++; if (!got) begin failures++; $display("FAIL bp_result_timeout: peak_valid=%b expected 1", bus.peak_valid); end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (bus.source_ready !== 1'b0 || bus.peak_valid !== 1'b1 || {bus.peak_bin, bus.peak_power} !== exp) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got ready %b valid %b bin %0d power %0d expected ready 0 valid 1 bin %0d power %0d", i, bus.source_ready, bus.peak_valid, bus.peak_bin, bus.peak_power, exp[RW-1 -: IW], exp[2*DW-1:0]);
      end
    end
    take_result();
    checks++; if (bus.peak_valid !== 1'b0 || bus.source_ready !== 1'b1) begin failures++; $display("FAIL bp_release: got valid %b ready %b expected 0 and 1", bus.peak_valid, bus.source_ready); end
  endtask

  task automatic test_reset_mid();
    int k, e0, v0, lat;
    bit got;
    logic [RW-1:0] obs, exp;
    // Reset after bin 299, with the last good result still on the outputs.
    clear_frame();
    fr_re[20] = 1500; fr_im[20] = 1500;
    e0 = err_pulses;
    send_frame(300, 1'b0, k);
    reset_n = 1'b0;
    #1;
    checks++; if (bus.source_ready !== 1'b1 || bus.peak_valid !== 1'b0 || bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_mid_frame: got ready %b valid %b err %b expected 1 0 0", bus.source_ready, bus.peak_valid, bus.frame_err); end
    checks++; if (bus.peak_bin !== '0 || bus.peak_power !== '0) begin failures++; $display("FAIL reset_mid_frame_data: got bin %0d power %0d expected 0 0", bus.peak_bin, bus.peak_power); end
    idle(2); reset_n = 1'b1; idle(5);
    checks++; if (err_pulses !== e0) begin failures++; $display("FAIL reset_mid_no_err: got %0d pulses expected 0", err_pulses - e0); end
    // Reset while a result is held.
    clear_frame();
    fr_re[77] = -1234; fr_im[77] = 999;
    send_frame(PTS, 1'b1, k);
    wait_result(got);
    checks++; if (!got) begin failures++; $display("FAIL hold_result_timeout: peak_valid=%b expected 1", bus.peak_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.peak_valid !== 1'b0 || bus.source_ready !== 1'b1 || bus.peak_bin !== '0 || bus.peak_power !== '0) begin failures++; $display("FAIL reset_in_hold: got valid %b ready %b bin %0d power %0d expected 0 1 0 0", bus.peak_valid, bus.source_ready, bus.peak_bin, bus.peak_power); end
    idle(2); reset_n = 1'b1;
    e0 = err_pulses; v0 = valid_rises;
    idle(10);
    checks++; if (err_pulses !== e0 || valid_rises !== v0) begin failures++; $display("FAIL reset_in_hold_quiet: got err %0d results %0d expected 0 and 0", err_pulses - e0, valid_rises - v0); end
    clear_frame();
    fr_re[400] = 64; fr_im[400] = 64;
    exp_q.push_back(model_peak());
    run_good_frame(got, obs, lat);
    exp = exp_q.pop_front();
    checks++; if (!got || obs !== exp || lat !== 3) begin failures++; $display("FAIL after_reset_peak: got valid %b bin %0d power %0d lat %0d expected bin %0d power %0d lat 3", got, obs[RW-1 -: IW], obs[2*DW-1:0], lat, exp[RW-1 -: IW], exp[2*DW-1:0]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clean();
    test_ties();
    test_full_scale();
    test_random();
    test_malformed();
    test_error_beat();
    test_backpressure();
    test_reset_mid();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
